// File: rtl/lbus_pkg.sv
// lbus_pkg: shared state encoding, bus widths and defaults for the local-bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lbus_pkg;

   localparam int LBUS_AW          = 8;
   localparam int LBUS_DW          = 32;
   localparam int LBUS_TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } lbus_state_t;

   // One requester's transaction as seen by the sequencer.
   typedef struct packed {
      logic               we;
      logic [LBUS_AW-1:0] addr;
      logic [LBUS_DW-1:0] wdata;
   } lbus_txn_t;

endpackage

// File: rtl/lbus_rr_pick.sv
// lbus_rr_pick: combinational round-robin picker, first set req bit at or above ptr, then wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module lbus_rr_pick
   import lbus_pkg::*;
#(
   parameter int NREQ = 4
)
(
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         win_oh,
   output logic [$clog2(NREQ)-1:0] win_idx
);

   localparam int            PW     = $clog2(NREQ);
   localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);

   logic [PW:0]   sum;
   logic [PW-1:0] j;

   // Scan offsets from farthest to nearest so the nearest requester at or after ptr wins.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      sum     = '0;
      j       = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         sum = {1'b0, ptr} + (PW+1)'(off);
         j   = (sum >= NREQ_W) ? PW'(sum - NREQ_W) : PW'(sum);
         if (req[j]) begin
            win_oh    = '0;
            win_oh[j] = 1'b1;
            win_idx   = j;
         end
      end
   end

endmodule

// File: rtl/lbus_arbiter.sv
// lbus_arbiter: round-robin arbiter and single-transaction sequencer for the 8b/32b local register bus.
// Latency: gnt the edge req is seen, strobe next cycle, done no earlier than 4 cycles after req.
// Backpressure: masters hold req until done; the slave stalls by withholding Ready (LBUS_TIMEOUT_EN bounds the wait).
module lbus_arbiter
   import lbus_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = LBUS_TIMEOUT_DEF
)
(
   input  logic                    Cclk,
   input  logic                    Reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         req_we,
   input  logic [NREQ*LBUS_AW-1:0] req_addr,
   input  logic [NREQ*LBUS_DW-1:0] req_wdata,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic                    err,
   output logic [LBUS_DW-1:0]      rdata,
   output logic [LBUS_AW-1:0]      Address,
   output logic [LBUS_DW-1:0]      DataOut,
   output logic                    Read,
   output logic                    Write,
   input  logic [LBUS_DW-1:0]      DataIn,
   input  logic                    Ready
);

   localparam int            PW       = $clog2(NREQ);
   localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

   // Out-of-range configurations are rejected at elaboration.
   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
      $error("lbus_arbiter: NREQ must be 2..8 and TIMEOUT 1..255");
   end

   lbus_state_t       state;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     cur_idx;
   logic              we_q;
   logic [NREQ-1:0]   win_oh;
   logic [PW-1:0]     win_idx;
   lbus_txn_t         sel;

   logic [LBUS_AW-1:0] slot_addr  [NREQ];
   logic [LBUS_DW-1:0] slot_wdata [NREQ];

`ifdef LBUS_TIMEOUT_EN
   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0] tcnt;
`else
   assign err = 1'b0;
`endif

   // Unpack the per-requester address and data slices.
   for (genvar g = 0; g < NREQ; g++) begin : g_slot
      assign slot_addr[g]  = req_addr[g*LBUS_AW +: LBUS_AW];
      assign slot_wdata[g] = req_wdata[g*LBUS_DW +: LBUS_DW];
   end

   lbus_rr_pick #(
      .NREQ    (NREQ)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   // Winner's transaction, muxed by the picker index.
   always_comb begin
      sel.we    = req_we[win_idx];
      sel.addr  = slot_addr[win_idx];
      sel.wdata = slot_wdata[win_idx];
   end

   // Sequencer: grant, one-cycle strobe, wait for Ready (or expiry), report done, advance ptr.
   always_ff @(posedge Cclk or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         ptr     <= '0;
         cur_idx <= '0;
         we_q    <= 1'b0;
         gnt     <= '0;
         done    <= '0;
         rdata   <= '0;
         Address <= '0;
         DataOut <= '0;
         Read    <= 1'b0;
         Write   <= 1'b0;
`ifdef LBUS_TIMEOUT_EN
         err     <= 1'b0;
         tcnt    <= '0;
`endif
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               // gnt from the previous transaction drops here unless a new one is granted.
               gnt <= win_oh;
               if (|req) begin
                  cur_idx <= win_idx;
                  we_q    <= sel.we;
                  Address <= sel.addr;
                  DataOut <= sel.wdata;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               Read  <= ~we_q;
               Write <= we_q;
`ifdef LBUS_TIMEOUT_EN
               tcnt  <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               Read  <= 1'b0;
               Write <= 1'b0;
               if (Ready) begin
                  // Ready takes priority over an expiry landing on the same edge.
                  rdata <= we_q ? '0 : DataIn;
`ifdef LBUS_TIMEOUT_EN
                  err   <= 1'b0;
`endif
                  state <= DONE;
               end
`ifdef LBUS_TIMEOUT_EN
               else begin
                  tcnt <= tcnt + 1'b1;
                  if (tcnt == TO_LAST) begin
                     rdata <= '0;
                     err   <= 1'b1;
                     state <= DONE;
                  end
               end
`endif
            end
            DONE: begin
               done  <= gnt;
               ptr   <= (cur_idx == PTR_LAST) ? '0 : cur_idx + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lbus_arbiter.sv
// tb_lbus_arbiter: randomized masters and slave around lbus_arbiter with a queue-based scoreboard.
// Latency: expected done cycle derived from the slave delay and the optional timeout.
// Backpressure: slave Ready delay chosen per transaction; LBUS_TIMEOUT_EN selects the expiry model.
module tb_lbus_arbiter;

   localparam int NREQ = 4;
   localparam int TO   = 15;
`ifdef LBUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              Cclk = 1'b0;
   logic              Reset;
   logic [NREQ-1:0]   req, req_we, gnt, done;
   logic [NREQ*8-1:0] req_addr;
   logic [NREQ*32-1:0] req_wdata;
   logic              err;
   logic [31:0]       rdata, DataOut, DataIn;
   logic [7:0]        Address;
   logic              Read, Write, Ready;

   lbus_arbiter #(
      .NREQ      (NREQ),
      .TIMEOUT   (TO)
   ) dut (
      .Cclk      (Cclk),
      .Reset     (Reset),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .Address   (Address),
      .DataOut   (DataOut),
      .Read      (Read),
      .Write     (Write),
      .DataIn    (DataIn),
      .Ready     (Ready)
   );

   always #5 Cclk = ~Cclk;

   typedef struct {
      bit          we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          dly;
      bit          exp_err;
      logic [31:0] exp_rdata;
   } exp_t;

   exp_t        sb_q [NREQ][$];
   logic [31:0] rmem [256];
   int          dly  [NREQ];
   bit          pend [NREQ];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int idx_of(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Round-robin rule: first requester at or after p, wrapping modulo NREQ.
   function automatic int rr_expect(input logic [NREQ-1:0] r, input int p);
      for (int off = 0; off < NREQ; off++) if (r[(p + off) % NREQ]) return (p + off) % NREQ;
      return -1;
   endfunction

   function automatic bit any_pend();
      for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic raise(input int i, input bit we, input logic [7:0] a, input logic [31:0] wd, input int d);
      exp_t e;
      req_we[i]            = we;
      req_addr[i*8 +: 8]   = a;
      req_wdata[i*32 +: 32] = wd;
      dly[i]               = d;
      req[i]               = 1'b1;
      pend[i]              = 1'b1;
      e.we        = we;
      e.addr      = a;
      e.wdata     = wd;
      e.dly       = d;
      e.exp_err   = TO_EN && (d >= TO);
      e.exp_rdata = (we || e.exp_err) ? 32'h0 : rmem[a];
      sb_q[i].push_back(e);
   endtask

   function automatic int rand_dly();
      return ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4));
   endfunction

   // One cycle of master behaviour, acting 2 time units after the edge.
   task automatic step(input int pct);
      bit jd [NREQ];
      @(posedge Cclk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
         jd[i] = 1'b0;
         if (pend[i] && done[i]) begin
            req[i]  = 1'b0;
            pend[i] = 1'b0;
            jd[i]   = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++)
         if (pend[i] && req[i] && gnt[i] && $urandom_range(0, 7) == 0) begin
            req[i]             = 1'b0;
            req_addr[i*8 +: 8] = 8'($urandom);
         end
      for (int i = 0; i < NREQ; i++)
         if (!pend[i] && !jd[i] && !Reset && int'($urandom_range(1, 100)) <= pct)
            raise(i, 1'($urandom), 8'($urandom), $urandom, rand_dly());
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (any_pend() && k < 400) begin
         step(0);
         k++;
      end
      chk(name, 32'(any_pend()), 32'd0);
      step(0);
      step(0);
   endtask

   // Slave: answers each strobe after the requester's chosen delay; pokes Ready during ISSUE too.
   initial begin : slave
      int              cnt;
      logic [7:0]      a;
      logic [NREQ-1:0] gnt_prev;
      cnt = -1; a = '0; gnt_prev = '0;
      Ready = 1'b0; DataIn = '0;
      forever begin
         @(negedge Cclk);
         Ready  = 1'b0;
         DataIn = $urandom;
         if (Reset) cnt = -1;
         else if (Read || Write) begin
            cnt = dly[idx_of(gnt)];
            a   = Address;
         end else if (|done) cnt = -1;
         else if (cnt < 0 && gnt != '0 && gnt != gnt_prev && $urandom_range(0, 1) == 1) Ready = 1'b1;
         if (cnt == 0) begin
            Ready  = 1'b1;
            DataIn = rmem[a];
         end
         if (cnt >= 0) cnt--;
         gnt_prev = gnt;
      end
   end

   // Monitor: predicts each grant from the sampled requests and checks strobe, hold and done.
   initial begin : monitor
      int              cyc, g_cyc, w, exp_n, n, mptr, last_strobe;
      bit              busy, skip;
      logic [NREQ-1:0] req_prev;
      exp_t            t;
      cyc = 0; g_cyc = 0; w = 0; exp_n = 0; mptr = 0; last_strobe = -100;
      busy = 1'b0; skip = 1'b1; req_prev = '0;
      t = '{default: 0};
      forever begin
         @(negedge Cclk);
         cyc++;
         if (Reset) begin
            busy = 1'b0; mptr = 0; skip = 1'b1; last_strobe = -100;
         end else if (skip) begin
            skip = 1'b0;
         end else if (busy) begin
            n = cyc - g_cyc;
            chk("gnt_hold", gnt, oh(w));
            if (n == 1) begin
               chk("strobe", {Read, Write}, {~t.we, t.we});
               chk("strobe_gap", 32'(cyc - last_strobe >= 4), 32'd1);
               last_strobe = cyc;
            end else chk("strobe_quiet", {Read, Write}, 2'b00);
            if (n >= 1) begin
               chk("address", Address, t.addr);
               chk("dataout", DataOut, t.wdata);
            end
            if (n < exp_n) chk("done_early", done, '0);
            else begin
               chk("done_pulse", done, oh(w));
               chk("err", err, t.exp_err);
               chk("rdata", rdata, t.exp_rdata);
               void'(sb_q[w].pop_front());
               mptr = (w + 1) % NREQ;
               busy = 1'b0;
            end
         end else begin
            chk("strobe_idle", {Read, Write}, 2'b00);
            chk("done_idle", done, '0);
            w = rr_expect(req_prev, mptr);
            if (w < 0) chk("gnt_idle", gnt, '0);
            else begin
               chk("gnt_grant", gnt, oh(w));
               if (sb_q[w].size() == 0) chk("sb_entry", 32'd0, 32'd1);
               else begin
                  t     = sb_q[w][0];
                  busy  = 1'b1;
                  g_cyc = cyc;
                  exp_n = t.exp_err ? 2 + TO : 3 + t.dly;
               end
            end
         end
         req_prev = req;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before 1000000");
      $fatal(1);
   end

   initial begin : driver
      int k;
      Reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin dly[i] = 0; pend[i] = 1'b0; end
      for (int a = 0; a < 256; a++) rmem[a] = $urandom;
      rmem[5] = 32'hA5A5_0001;
      repeat (3) @(posedge Cclk);
      #2;
      chk("rst_gnt", gnt, '0);       chk("rst_done", done, '0);
      chk("rst_err", err, 1'b0);     chk("rst_rdata", rdata, 32'h0);
      chk("rst_addr", Address, 8'h0); chk("rst_dout", DataOut, 32'h0);
      chk("rst_read", Read, 1'b0);   chk("rst_write", Write, 1'b0);
      Reset = 1'b0;
      step(0); step(0);

      raise(1, 1'b1, 8'h12, 32'hDEADBEEF, 0);
      drain("single_write");
      raise(2, 1'b0, 8'h05, 32'h1111_2222, 2);
      drain("single_read");
      raise(3, 1'b0, 8'h40, $urandom, 40);
      drain("long_wait");
      raise(0, 1'b0, 8'h41, $urandom, TO - 1);
      drain("ready_at_expiry");
      raise(1, 1'b0, 8'h42, $urandom, TO);
      drain("ready_after_expiry");
      raise(2, 1'b1, 8'h43, $urandom, 1);
      drain("after_expiry");

      for (int i = 0; i < NREQ; i++) raise(i, 1'($urandom), 8'($urandom), $urandom, 0);
      repeat (60) step(100);
      drain("rr_all");

      repeat (600) step(30);
      drain("random");

      raise(2, 1'b0, 8'h33, 32'hCAFE_F00D, 60);
      k = 0;
      while (!Read && k < 20) begin step(0); k++; end
      chk("reach_strobe", Read, 1'b1);
      step(0); step(0);
      Reset = 1'b1;
      #1;
      chk("arst_gnt", gnt, '0);       chk("arst_done", done, '0);
      chk("arst_err", err, 1'b0);     chk("arst_rdata", rdata, 32'h0);
      chk("arst_addr", Address, 8'h0); chk("arst_dout", DataOut, 32'h0);
      chk("arst_read", Read, 1'b0);   chk("arst_write", Write, 1'b0);
      req = '0;
      for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; sb_q[i].delete(); end
      repeat (2) @(posedge Cclk);
      #2;
      Reset = 1'b0;
      for (int i = 0; i < NREQ; i++) raise(i, 1'($urandom), 8'($urandom), $urandom, 0);
      step(0);
      chk("first_after_reset", gnt, 4'b0001);
      repeat (200) step(50);
      drain("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lbus_arbiter.md
# lbus_arbiter

Round-robin arbiter and transaction sequencer for the 8-bit-address / 32-bit-data local register bus inside TrigTDC. It lets several on-chip masters share one local bus: the TRBNet translator, the power-up register initializer, and the calibration sequencer. It grants one requester at a time, issues a single-cycle Read or Write strobe, waits for the slave's Ready, and returns read data plus an error flag. Without the arbiter, each master would have to own the bus exclusively.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 15, Ready-wait cycles before error (1..255)
- Cclk  in  1  bus clock; all logic on posedge
- Reset  in  1  asynchronous, active-high reset
- req  in  NREQ  request, one bit per master; held until done
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*8  packed addresses; slice i = [8i+7:8i]
- req_wdata  in  NREQ*32  packed write data; slice i = [32i+31:32i]
- gnt  out  NREQ  one-hot grant, high from grant until done cycle inclusive
- done  out  NREQ  one-cycle completion pulse to the granted master
- err  out  1  valid with done; 1 = timeout
- rdata  out  32  valid with done; captured DataIn (0 on write or timeout)
- Address  out  8  local bus address
- DataOut  out  32  local bus write data
- Read  out  1  single-cycle read strobe
- Write  out  1  single-cycle write strobe
- DataIn  in  32  local bus read data, valid with Ready
- Ready  in  1  slave completion

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** if any req bit is set, select the winner by round-robin starting at pointer `ptr`. Register gnt, Address, DataOut and the we flag from the winner's slices, then go to ISSUE.
- **ISSUE:** assert Write (we=1) or Read (we=0) for exactly one cycle, then go to WAIT.
- **WAIT:** on Ready=1, capture DataIn into rdata for a read (rdata=0 for a write), set err=0, and go to DONE. Ready during ISSUE is ignored.
- **DONE:** pulse done[winner] with err/rdata valid, set ptr=(winner+1) mod NREQ, clear gnt after this cycle, and return to IDLE.
- Address and DataOut hold their values from ISSUE through DONE. After DONE they hold the last values; the strobes are the only qualifiers.
- A req bit dropped mid-transaction is ignored; the transaction completes and done still pulses.
- A master must deassert req no later than the cycle after done, or it is treated as a new request.
- `ptr` uses $clog2(NREQ) bits with explicit wrap at NREQ-1 → 0, so non-power-of-2 NREQ is supported.

## Timing
- Reset values: gnt=0, done=0, err=0, rdata=0, Address=0, DataOut=0, Read=0, Write=0, state=IDLE, ptr=0, timeout counter=0.
- Reset asserted mid-transaction aborts it: no done pulse and strobes drop immediately.
- Latency, req seen at edge k: gnt valid after k; strobe during k+1..k+2; earliest Ready sampled at k+2; done pulse in cycle k+3..k+4 (4 cycles minimum, request to done).
- Back-to-back: IDLE occupies one cycle between transactions, so maximum throughput is one transaction per 4 cycles.
- Simultaneous requests: lowest index at or above ptr wins, then wrap-around. After reset, requester 0 wins first.

## Configuration
- LBUS_TIMEOUT_EN defined: a counter of $clog2(TIMEOUT+1) bits clears on entering WAIT and increments each WAIT cycle without Ready. At count == TIMEOUT it goes to DONE with err=1, rdata=0. Ready arriving in the same cycle as expiry wins (err=0).
- LBUS_TIMEOUT_EN undefined: WAIT waits indefinitely, err is tied 0, and no counter is built.

## Structure
- Package lbus_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, DONE);
  - LBUS_AW=8 and LBUS_DW=32;
  - the default TIMEOUT constant.
- Sub-module lbus_rr_pick: combinational round-robin picker with inputs req and ptr, outputs a one-hot winner and its index. The top holds the FSM, registers, counter and muxes.

## Test plan
- **Single write:** req[1]=1, we=1, addr=0x12, wdata=0xDEADBEEF; slave returns Ready one cycle after the strobe. Expect one Write pulse with Address=0x12 and DataOut=0xDEADBEEF, then done[1] with err=0, 4 cycles after req.
- **Single read:** req[2]=1, we=0, addr=0x05; slave drives DataIn=0xA5A5_0001 with Ready three cycles after the strobe. Expect rdata=0xA5A50001 and err=0 with done[2].
- **Round-robin:** all four reqs held continuously from reset. Expect grant order 0,1,2,3,0; each gnt one-hot; no two strobes within 4 cycles.
- **Timeout (LBUS_TIMEOUT_EN, TIMEOUT=15):** read with Ready never asserted. Expect done with err=1 and rdata=0 exactly 15 WAIT cycles after entry; the next request is served normally. Same test without the macro: the arbiter stays in WAIT until Ready.
- **Reset mid-WAIT:** assert Reset during WAIT. Expect all outputs 0 immediately, no done pulse, ptr=0, and requester 0 granted first after release.
- **Ready/expiry collision:** Ready arrives on the same cycle the count reaches TIMEOUT. Expect err=0 and DataIn captured.
